ram_ctrl: RTL and testbench
===========================

Name: ram_ctrl

Overview:
Single-clock request/response front end that acts as the initiator for the team's 1R1W synchronous RAM. It accepts read and write requests on a valid/ready port and drives the RAM's write and read ports. It tracks the RAM's one-cycle registered read latency and returns read data in order through a small response FIFO with backpressure. Both RAM clocks are tied to this block's clk at the parent.

Parameters:
D_WIDTH, 16, data word width; must match the RAM instance.
A_WIDTH, 4, address width; must match the RAM instance.
RSP_DEPTH, 3, response FIFO entries; minimum 2; 3 gives full read throughput.

Ports:
clk  in  1  single clock; also drives the RAM clk_write and clk_read at the parent.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request this cycle.
req_write  in  1  1 = write, 0 = read.
req_addr  in  A_WIDTH  request address.
req_wdata  in  D_WIDTH  write data; ignored for reads.
rsp_valid  out  1  read data available.
rsp_ready  in  1  consumer takes the response.
rsp_rdata  out  D_WIDTH  read data, in request order.
busy  out  1  a read is in flight or the FIFO is non-empty.
mem_address_write  out  A_WIDTH  to RAM address_write.
mem_data_write  out  D_WIDTH  to RAM data_write.
mem_write_enable  out  1  to RAM write_enable.
mem_address_read  out  A_WIDTH  to RAM address_read.
mem_data_read  in  D_WIDTH  from RAM data_read; valid one cycle after the RAM samples the address.

Behaviour:
- Clock and reset are decided: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset, asynchronous on rst_n low:
  - rd_pending=0, fifo count=0, read and write pointers=0.
  - rsp_valid=0, busy=0, mem_write_enable=0.
  - RAM contents are not cleared.
- Accept: a request is accepted when req_valid && req_ready are both high at a rising edge.
- req_ready = (fifo_count + rd_pending) < RSP_DEPTH.
  - Registered terms only; there is no combinational path from rsp_ready or req_* to req_ready.
  - The same rule applies to reads and writes, so writes are also held off when the FIFO is full.
- Write path, combinational:
  - mem_address_write = req_addr.
  - mem_data_write = req_wdata.
  - mem_write_enable = req_valid && req_ready && req_write.
  - The RAM commits the word at the accepting edge. Writes produce no response.
- Read path:
  - mem_address_read = req_addr at all times.
  - At the accepting edge E0 the RAM registers data, and rd_pending is set to 1.
  - At E0+1, if rd_pending=1, mem_data_read is pushed into the FIFO. rd_pending becomes 1 again only if another read was accepted at E0+1.
  - rsp_valid is high in the cycle after E0+1, i.e. 2 clocks after accept.
- Response FIFO:
  - rsp_valid = (count != 0); rsp_rdata = entry at the head, read pointer.
  - Pop on rsp_valid && rsp_ready. A push and a pop in the same edge leave count unchanged.
  - Pointers wrap modulo RSP_DEPTH.
  - The credit rule guarantees no push when full. An overflow indicates a design bug; assert on it in simulation.
- Ordering:
  - Responses come back strictly in request order.
  - A read to the address written by the immediately preceding accepted write returns the new data, because the write commits one edge before the read sample.
- Throughput with RSP_DEPTH=3 and rsp_ready held at 1: one request per cycle, sustained.
- busy = rd_pending || (count != 0).
- Reset mid-operation: an in-flight read is discarded and the FIFO is emptied. A write accepted before reset asserts remains in the RAM.

Decomposition:
- Shared package ram_pkg holds:
  - default D_WIDTH and A_WIDTH constants;
  - RSP_DEPTH default;
  - a request struct typedef {write, addr, wdata}.
- One sub-module: ram_rsp_fifo, a synchronous FIFO of RSP_DEPTH x D_WIDTH with push, pop, count, full and empty.
- Top-level testbench instantiates ram_ctrl plus the RAM, with both RAM clocks tied to clk.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n low for 3 cycles, then release.
  - Required: rsp_valid=0, busy=0, req_ready=1, mem_write_enable=0 throughout reset and after.
- Write then read back:
  - Stimulus: write addr 4 data 0xBEEF, next cycle read addr 4.
  - Required: rsp_valid 2 cycles after the read accept, rsp_rdata=0xBEEF.
- Streaming reads:
  - Stimulus: after writing addrs 0-15 with data 0x1000+addr, issue reads 0-15 back-to-back with rsp_ready=1.
  - Required: req_ready never drops; 16 responses 0x1000..0x100F in order on consecutive cycles.
- Backpressure:
  - Stimulus: rsp_ready=0, issue reads to addrs 1, 2, 3, 4.
  - Required: req_ready drops after 3 reads are accepted; on raising rsp_ready, data returns for addrs 1, 2, 3, then addr 4 is accepted and returned. No loss, no duplicates.
- Simultaneous push and pop:
  - Stimulus: with count=1, accept a read while popping the head.
  - Required: count stays 1 and the popped data is correct.
- Reset mid-read:
  - Stimulus: assert rst_n low 1 cycle after a read accept.
  - Required: rsp_valid stays 0, busy=0, and a subsequent read returns the correct stored value.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_ctrl shared definitions.
// Default geometry and the request bundle.
package ram_pkg;

  localparam int D_WIDTH_DEF   = 16;
  localparam int A_WIDTH_DEF   = 4;
  localparam int RSP_DEPTH_DEF = 3;

  typedef struct packed {
    logic                   write;
    logic [A_WIDTH_DEF-1:0] addr;
    logic [D_WIDTH_DEF-1:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/ram_ctrl_if.sv
// Request/response port of the RAM front end.
// master drives requests, slave is the controller.
interface ram_ctrl_if
  import ram_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int A_WIDTH = A_WIDTH_DEF
) ();

  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [A_WIDTH-1:0] req_addr;
  logic [D_WIDTH-1:0] req_wdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [D_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram_rsp_fifo.sv
// Read-response FIFO of the RAM front end.
// Head word is presented combinationally.
module ram_rsp_fifo
  import ram_pkg::*;
#(
  parameter  int D_WIDTH = D_WIDTH_DEF,
  parameter  int DEPTH   = RSP_DEPTH_DEF,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic [D_WIDTH-1:0] din_i,
  input  logic               pop_i,
  output logic [D_WIDTH-1:0] dout_o,
  output logic [CW-1:0]      count_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               do_push, do_pop;

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push_i;
  assign do_pop  = pop_i && !empty_o;

  assign dout_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

  // Next pointers and occupancy.
  always_comb begin
    wptr_d = do_push ? bump(wptr_q) : wptr_q;
    rptr_d = do_pop  ? bump(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    unique case (1'b1)
      (do_push && !do_pop): cnt_d = cnt_q + CW'(1);
      (do_pop && !do_push): cnt_d = cnt_q - CW'(1);
      default:              cnt_d = cnt_q;
    endcase
  end

  // Pointer and count state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/ram_ctrl.sv
// Initiator for the 1R1W synchronous RAM.
// Credits cover in-flight reads plus queued data.
module ram_ctrl
  import ram_pkg::*;
#(
  parameter  int D_WIDTH   = D_WIDTH_DEF,
  parameter  int A_WIDTH   = A_WIDTH_DEF,
  parameter  int RSP_DEPTH = RSP_DEPTH_DEF,
  localparam int CW        = $clog2(RSP_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  ram_ctrl_if.slave          bus,
  output logic               busy,
  output logic [A_WIDTH-1:0] mem_address_write,
  output logic [D_WIDTH-1:0] mem_data_write,
  output logic               mem_write_enable,
  output logic [A_WIDTH-1:0] mem_address_read,
  input  logic [D_WIDTH-1:0] mem_data_read
);

  logic          rd_pending_q, rd_pending_d;
  logic [CW-1:0] cnt;
  logic [CW:0]   credit;
  logic          full, empty;
  logic          accept, push, pop;

  assign credit = {1'b0, cnt}
                + {{CW{1'b0}}, rd_pending_q};

  assign bus.req_ready =
    credit < (CW + 1)'(RSP_DEPTH);

  assign accept = bus.req_valid && bus.req_ready;

  assign mem_address_write = bus.req_addr;
  assign mem_data_write    = bus.req_wdata;
  assign mem_write_enable  = accept && bus.req_write;
  assign mem_address_read  = bus.req_addr;

  assign push = rd_pending_q;
  assign pop  = bus.rsp_valid && bus.rsp_ready;

  assign bus.rsp_valid = !empty;
  assign busy          = rd_pending_q || !empty;

  // A read accepted now has RAM data one edge later.
  always_comb begin
    rd_pending_d = accept && !bus.req_write;
  end

  // Read-in-flight flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending_q <= 1'b0;
    end else begin
      rd_pending_q <= rd_pending_d;
    end
  end

  ram_rsp_fifo #(
    .D_WIDTH (D_WIDTH),
    .DEPTH   (RSP_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (mem_data_read),
    .pop_i   (pop),
    .dout_o  (bus.rsp_rdata),
    .count_o (cnt),
    .full_o  (full),
    .empty_o (empty)
  );

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && full)
  ) else $error("response fifo overflow");

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl with a behavioural RAM.
// Queue model plus directed literal checks.
module tb_ram_ctrl;
  import ram_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int DEP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_ctrl_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus ();

  logic          busy, mem_we;
  logic [AW-1:0] mem_aw, mem_ar;
  logic [DW-1:0] mem_dw, mem_dr;

  ram_ctrl #(
    .D_WIDTH   (DW),
    .A_WIDTH   (AW),
    .RSP_DEPTH (DEP)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus),
    .busy              (busy),
    .mem_address_write (mem_aw),
    .mem_data_write    (mem_dw),
    .mem_write_enable  (mem_we),
    .mem_address_read  (mem_ar),
    .mem_data_read     (mem_dr)
  );

  logic [DW-1:0] ram [16];
  logic [DW-1:0] ram_rd_q;
  assign mem_dr = ram_rd_q;

  // 1R1W RAM, both ports on clk.
  always @(posedge clk) begin
    if (mem_we) ram[mem_aw] <= mem_dw;
    ram_rd_q <= ram[mem_ar];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: memory image plus queue
  // of reads accepted and not yet consumed.
  typedef struct {
    logic [DW-1:0] d;
    int            k;
  } pend_t;

  logic [DW-1:0] mmem [16];
  pend_t         mq[$];
  int            ecount = 0;

  always @(negedge clk) begin : model
    logic er, ev;
    if (!rst_n) begin
      mq.delete();
      check("rst_valid", 32'(bus.rsp_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_we", 32'(mem_we), 0);
      check("rst_ready", 32'(bus.req_ready), 1);
    end else begin
      er = mq.size() < DEP;
      ev = mq.size() != 0 && ecount >= mq[0].k + 1;
      check("ready", 32'(bus.req_ready), 32'(er));
      check("valid", 32'(bus.rsp_valid), 32'(ev));
      check("busy", 32'(busy), 32'(mq.size() != 0));
      check("we", 32'(mem_we),
            32'(bus.req_valid && er && bus.req_write));
      check("aw", 32'(mem_aw), 32'(bus.req_addr));
      check("ar", 32'(mem_ar), 32'(bus.req_addr));
      check("dw", 32'(mem_dw), 32'(bus.req_wdata));
      if (ev) check("rdata", 32'(bus.rsp_rdata), 32'(mq[0].d));
      ecount++;
      if (ev && bus.rsp_ready) void'(mq.pop_front());
      if (bus.req_valid && er) begin
        if (bus.req_write)
          mmem[bus.req_addr] = bus.req_wdata;
        else
          mq.push_back('{d: mmem[bus.req_addr], k: ecount});
      end
    end
  end

  logic [DW-1:0] got[$];
  int            gc[$];

  // Log every consumed response with its cycle.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      got.push_back(bus.rsp_rdata);
      gc.push_back(cyc);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic w,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 64) begin
      n++;
      @(negedge clk);
    end
    check("accept_timeout", 32'(n >= 64), 0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_req(input logic w,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    set_req(w, a, d);
    wait_accept();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(bus.req_ready), 1);
    check("idle_busy", 32'(busy), 0);
    idle(1);

    // write then read back
    do_req(1'b1, 4'd4, 16'hBEEF);
    do_req(1'b0, 4'd4, 16'h0);
    @(negedge clk);
    check("wr_rd_lat1", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    check("wr_rd_lat2", 32'(bus.rsp_valid), 1);
    check("wr_rd_data", 32'(bus.rsp_rdata), 32'h0000BEEF);
    idle(3);

    // streaming
    for (int a = 0; a < 16; a++)
      do_req(1'b1, AW'(a), DW'(16'h1000 + a));
    got.delete();
    gc.delete();
    c0 = cyc;
    for (int a = 0; a < 16; a++)
      do_req(1'b0, AW'(a), 16'h0);
    check("stream_cycles", 32'(cyc - c0), 16);
    idle(5);
    check("stream_n", 32'(got.size()), 16);
    for (int i = 0; i < got.size(); i++) begin
      check("stream_data", 32'(got[i]), 32'(16'h1000 + i));
      if (i > 0)
        check("stream_gap", 32'(gc[i] - gc[i-1]), 1);
    end

    // backpressure
    bus.rsp_ready = 1'b0;
    got.delete();
    do_req(1'b0, 4'd1, 16'h0);
    do_req(1'b0, 4'd2, 16'h0);
    do_req(1'b0, 4'd3, 16'h0);
    set_req(1'b0, 4'd4, 16'h0);
    @(negedge clk);
    check("bp_ready0", 32'(bus.req_ready), 0);
    @(negedge clk);
    check("bp_ready1", 32'(bus.req_ready), 0);
    check("bp_none", 32'(got.size()), 0);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    wait_accept();
    idle(6);
    check("bp_n", 32'(got.size()), 4);
    for (int i = 0; i < got.size(); i++)
      check("bp_data", 32'(got[i]), 32'(16'h1001 + i));

    // simultaneous push and pop
    bus.rsp_ready = 1'b0;
    got.delete();
    do_req(1'b0, 4'd5, 16'h0);
    do_req(1'b0, 4'd6, 16'h0);
    bus.rsp_ready = 1'b1;
    do_req(1'b0, 4'd7, 16'h0);
    @(negedge clk);
    check("pp_count", 32'(dut.u_fifo.count_o), 1);
    idle(5);
    check("pp_n", 32'(got.size()), 3);
    for (int i = 0; i < got.size(); i++)
      check("pp_data", 32'(got[i]), 32'(16'h1005 + i));

    // reset mid-read; the earlier write survives
    do_req(1'b1, 4'd9, 16'hA5A5);
    got.delete();
    do_req(1'b0, 4'd8, 16'h0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("mr_valid", 32'(bus.rsp_valid), 0);
    check("mr_busy", 32'(busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    check("mr_none", 32'(got.size()), 0);
    do_req(1'b0, 4'd8, 16'h0);
    do_req(1'b0, 4'd9, 16'h0);
    idle(4);
    check("mr_n", 32'(got.size()), 2);
    if (got.size() == 2) begin
      check("mr_data8", 32'(got[0]), 32'h00001008);
      check("mr_data9", 32'(got[1]), 32'h0000A5A5);
    end

    // randomized traffic against the model
    repeat (600) begin
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_write = ($urandom_range(0, 2) == 0);
      bus.req_addr  = AW'($urandom_range(0, 15));
      bus.req_wdata = DW'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    idle(8);
    check("drain_busy", 32'(busy), 0);
    check("drain_valid", 32'(bus.rsp_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
